instr_imm_decoder: RTL and testbench

//  Front half of the immediate path. Registers 32-bit RV32I fetch words and classifies each one to a cuop_t

---
 rtl/instr_imm_decoder_if.sv | 24 ++
 rtl/instr_imm_decoder.sv | 178 +++++++++++++++++
 tb/tb_instr_imm_decoder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_imm_decoder_if.sv
// instr_imm_decoder_if: fetch-side and decode-side valid/ready bundle for instr_imm_decoder.
// out_cuop carries a cpu_types_pkg::cuop_t value as a plain 6-bit vector.
interface instr_imm_decoder_if #(parameter int IMM_W = 20);
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_cuop;
  logic [IMM_W-1:0] out_imm;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic             out_illegal;
  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_cuop, out_imm, out_rd, out_rs1, out_rs2, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_cuop, out_imm, out_rd, out_rs1, out_rs2, out_illegal
  );
endinterface

// File: rtl/instr_imm_decoder.sv
// instr_imm_decoder: decodes RV32I fetch words into cuop/rd/rs1/rs2/packed imm behind a 1-2 entry skid buffer.
// Optional feature: define DEC_ILLEGAL_CHECK_EN to flag unknown encodings on out_illegal.
package cpu_types_pkg;
  typedef enum logic [5:0] {
    CU_NOP, CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
    CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
    CU_SB, CU_SH, CU_SW,
    CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI, CU_SLLI, CU_SRLI, CU_SRAI,
    CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND
  } cuop_t;
endpackage

module instr_imm_decoder #(
  parameter int IMM_W = 20,
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               nRst,
  instr_imm_decoder_if.slave bus
);
  import cpu_types_pkg::*;

  typedef struct packed {
    cuop_t            cuop;
    logic [IMM_W-1:0] imm;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             ill;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, PART, FULL} state_t;

  function automatic ent_t decode(input logic [31:0] i);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [19:0] imm;
    logic        rd_en, rs1_en, rs2_en;
    cuop_t       cu;
    ent_t        e;
    f3 = i[14:12];
    f7 = i[31:25];
    cu = CU_NOP;
    imm = '0;
    {rd_en, rs1_en, rs2_en} = 3'b000;
    case (i[6:0])
      7'h37: begin cu = CU_LUI;   imm = i[31:12]; rd_en = 1'b1; end
      7'h17: begin cu = CU_AUIPC; imm = i[31:12]; rd_en = 1'b1; end
      7'h6F: begin cu = CU_JAL;   imm = {i[31], i[19:12], i[20], i[30:21]}; rd_en = 1'b1; end
      7'h67: begin
        cu = f3 == 3'd0 ? CU_JALR : CU_NOP;
        imm = {8'b0, i[31:20]};
        {rd_en, rs1_en} = 2'b11;
      end
      7'h03: begin
        case (f3)
          3'd0: cu = CU_LB;
          3'd1: cu = CU_LH;
          3'd2: cu = CU_LW;
          3'd4: cu = CU_LBU;
          3'd5: cu = CU_LHU;
          default: ;
        endcase
        imm = {8'b0, i[31:20]};
        {rd_en, rs1_en} = 2'b11;
      end
      7'h23: begin
        case (f3)
          3'd0: cu = CU_SB;
          3'd1: cu = CU_SH;
          3'd2: cu = CU_SW;
          default: ;
        endcase
        imm = {8'b0, i[31:25], i[11:7]};
        {rs1_en, rs2_en} = 2'b11;
      end
      7'h63: begin
        case (f3)
          3'd0: cu = CU_BEQ;
          3'd1: cu = CU_BNE;
          3'd4: cu = CU_BLT;
          3'd5: cu = CU_BGE;
          3'd6: cu = CU_BLTU;
          3'd7: cu = CU_BGEU;
          default: ;
        endcase
        imm = {8'b0, i[31], i[7], i[30:25], i[11:8]};
        {rs1_en, rs2_en} = 2'b11;
      end
      7'h13: begin
        case (f3)
          3'd0: cu = CU_ADDI;
          3'd1: cu = f7 == 7'h00 ? CU_SLLI : CU_NOP;
          3'd2: cu = CU_SLTI;
          3'd3: cu = CU_SLTIU;
          3'd4: cu = CU_XORI;
          3'd5: cu = f7 == 7'h00 ? CU_SRLI : f7 == 7'h20 ? CU_SRAI : CU_NOP;
          3'd6: cu = CU_ORI;
          default: cu = CU_ANDI;
        endcase
        imm = {8'b0, i[31:20]};
        {rd_en, rs1_en} = 2'b11;
      end
      7'h33: begin
        // only funct7 0x00/0x20 are RV32I; 0x20 selects SUB/SRA
        case (f3)
          3'd0: cu = f7 == 7'h00 ? CU_ADD : f7 == 7'h20 ? CU_SUB : CU_NOP;
          3'd1: cu = f7 == 7'h00 ? CU_SLL : CU_NOP;
          3'd2: cu = f7 == 7'h00 ? CU_SLT : CU_NOP;
          3'd3: cu = f7 == 7'h00 ? CU_SLTU : CU_NOP;
          3'd4: cu = f7 == 7'h00 ? CU_XOR : CU_NOP;
          3'd5: cu = f7 == 7'h00 ? CU_SRL : f7 == 7'h20 ? CU_SRA : CU_NOP;
          3'd6: cu = f7 == 7'h00 ? CU_OR : CU_NOP;
          default: cu = f7 == 7'h00 ? CU_AND : CU_NOP;
        endcase
        {rd_en, rs1_en, rs2_en} = 3'b111;
      end
      default: ;
    endcase
    e.cuop = cu;
    e.imm  = cu == CU_NOP ? '0 : IMM_W'(imm);
    e.rd   = cu != CU_NOP && rd_en  ? i[11:7]  : 5'd0;
    e.rs1  = cu != CU_NOP && rs1_en ? i[19:15] : 5'd0;
    e.rs2  = cu != CU_NOP && rs2_en ? i[24:20] : 5'd0;
`ifdef DEC_ILLEGAL_CHECK_EN
    e.ill  = cu == CU_NOP;
`else
    e.ill  = 1'b0;
`endif
    return e;
  endfunction

  state_t state_q, state_d;
  ent_t   head_q, head_d, skid_q, skid_d, dec_w;
  logic   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic   acc, drn;

  assign dec_w = decode(bus.in_instr);

  always_comb begin
    acc = bus.in_valid & in_ready_q & ~bus.flush;
    drn = out_valid_q & bus.out_ready;
    head_d = acc && (state_q == EMPTY || drn) ? dec_w : drn ? skid_q : head_q;
    skid_d = acc && !drn && state_q == PART ? dec_w : skid_q;
    state_d = bus.flush ? EMPTY :
              state_q == EMPTY ? (acc ? (DEPTH == 1 ? FULL : PART) : EMPTY) :
              state_q == PART  ? (acc && !drn ? FULL : drn && !acc ? EMPTY : PART) :
              state_q == FULL  ? (drn ? (DEPTH == 1 ? EMPTY : PART) : FULL) : EMPTY;
    in_ready_d  = state_d != FULL;
    out_valid_d = state_d != EMPTY;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_cuop    = head_q.cuop;
  assign bus.out_imm     = head_q.imm;
  assign bus.out_rd      = head_q.rd;
  assign bus.out_rs1     = head_q.rs1;
  assign bus.out_rs2     = head_q.rs2;
  assign bus.out_illegal = head_q.ill;
endmodule

// File: tb/tb_instr_imm_decoder.sv
// tb_instr_imm_decoder: table vectors, handshake corner sequences and random traffic vs an opcode-table model.
module tb_instr_imm_decoder;
  import cpu_types_pkg::*;

  localparam int DEPTH = 2;
`ifdef DEC_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef enum {F_R, F_I, F_S, F_B, F_U, F_J} fmt_e;
  typedef struct packed {
    cuop_t       cuop;
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ill;
  } exp_t;
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    cuop_t       cu;
    fmt_e        fmt;
  } pat_t;
  typedef struct packed {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  logic clk, nRst;
  int   checks = 0, errors = 0;
  pat_t pats[$];
  vec_t tbl[$];
  exp_t q[$];

  instr_imm_decoder_if #(.IMM_W(20)) bus();
  instr_imm_decoder #(.IMM_W(20), .DEPTH(DEPTH)) dut (.clk(clk), .nRst(nRst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input logic [31:0] m, input logic [31:0] v, input cuop_t c, input fmt_e f);
    pats.push_back('{m, v, c, f});
  endtask

  task automatic init_pats();
    add(32'h7F, 32'h37, CU_LUI, F_U);        add(32'h7F, 32'h17, CU_AUIPC, F_U);
    add(32'h7F, 32'h6F, CU_JAL, F_J);        add(32'h707F, 32'h67, CU_JALR, F_I);
    add(32'h707F, 32'h63, CU_BEQ, F_B);      add(32'h707F, 32'h1063, CU_BNE, F_B);
    add(32'h707F, 32'h4063, CU_BLT, F_B);    add(32'h707F, 32'h5063, CU_BGE, F_B);
    add(32'h707F, 32'h6063, CU_BLTU, F_B);   add(32'h707F, 32'h7063, CU_BGEU, F_B);
    add(32'h707F, 32'h03, CU_LB, F_I);       add(32'h707F, 32'h1003, CU_LH, F_I);
    add(32'h707F, 32'h2003, CU_LW, F_I);     add(32'h707F, 32'h4003, CU_LBU, F_I);
    add(32'h707F, 32'h5003, CU_LHU, F_I);    add(32'h707F, 32'h23, CU_SB, F_S);
    add(32'h707F, 32'h1023, CU_SH, F_S);     add(32'h707F, 32'h2023, CU_SW, F_S);
    add(32'h707F, 32'h13, CU_ADDI, F_I);     add(32'h707F, 32'h2013, CU_SLTI, F_I);
    add(32'h707F, 32'h3013, CU_SLTIU, F_I);  add(32'h707F, 32'h4013, CU_XORI, F_I);
    add(32'h707F, 32'h6013, CU_ORI, F_I);    add(32'h707F, 32'h7013, CU_ANDI, F_I);
    add(32'hFE00707F, 32'h1013, CU_SLLI, F_I);
    add(32'hFE00707F, 32'h5013, CU_SRLI, F_I);
    add(32'hFE00707F, 32'h40005013, CU_SRAI, F_I);
    add(32'hFE00707F, 32'h33, CU_ADD, F_R);  add(32'hFE00707F, 32'h40000033, CU_SUB, F_R);
    add(32'hFE00707F, 32'h1033, CU_SLL, F_R); add(32'hFE00707F, 32'h2033, CU_SLT, F_R);
    add(32'hFE00707F, 32'h3033, CU_SLTU, F_R); add(32'hFE00707F, 32'h4033, CU_XOR, F_R);
    add(32'hFE00707F, 32'h5033, CU_SRL, F_R); add(32'hFE00707F, 32'h40005033, CU_SRA, F_R);
    add(32'hFE00707F, 32'h6033, CU_OR, F_R);  add(32'hFE00707F, 32'h7033, CU_AND, F_R);
  endtask

  // Reconstructs the ISA immediate, then keeps the bits the sign extender expects.
  function automatic exp_t model(input logic [31:0] i);
    exp_t        e;
    int          hit;
    logic [12:0] off_b;
    logic [20:0] off_j;
    e = '0;
    hit = -1;
    for (int k = 0; k < pats.size(); k++)
      if (hit < 0 && (i & pats[k].mask) == pats[k].match) hit = k;
    if (hit < 0) begin
      e.ill = ILL_EN;
      return e;
    end
    e.cuop = pats[hit].cu;
    case (pats[hit].fmt)
      F_R: begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; end
      F_I: begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = 20'(i[31:20]); end
      F_S: begin e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = 20'({i[31:25], i[11:7]}); end
      F_B: begin
        e.rs1 = i[19:15]; e.rs2 = i[24:20];
        off_b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        e.imm = 20'(off_b >> 1);
      end
      F_U: begin e.rd = i[11:7]; e.imm = i[31:12]; end
      default: begin
        e.rd = i[11:7];
        off_j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        e.imm = off_j[20:1];
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic check_ent(input string t, input exp_t e);
    chk({t, ".cuop"}, 32'(bus.out_cuop), 32'(e.cuop));
    chk({t, ".imm"}, 32'(bus.out_imm), 32'(e.imm));
    chk({t, ".rd"}, 32'(bus.out_rd), 32'(e.rd));
    chk({t, ".rs1"}, 32'(bus.out_rs1), 32'(e.rs1));
    chk({t, ".rs2"}, 32'(bus.out_rs2), 32'(e.rs2));
    chk({t, ".illegal"}, 32'(bus.out_illegal), 32'(e.ill));
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    if (q.size() != 0) check_ent("head", q[0]);
  endtask

  // Called at a negedge: checks the current outputs, drives one cycle, advances the model.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic fl, input logic ordy);
    int occ;
    check_outputs();
    bus.in_valid = iv;
    bus.in_instr = ins;
    bus.flush = fl;
    bus.out_ready = ordy;
    occ = q.size();
    if (fl) q.delete();
    else begin
      if (occ != 0 && ordy) void'(q.pop_front());
      if (iv && occ < DEPTH) q.push_back(model(ins));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ins;
    int          k;
    init_pats();
    tbl.push_back('{32'hABCDE2B7, '{CU_LUI, 20'hABCDE, 5'd5, 5'd0, 5'd0, 1'b0}});
    tbl.push_back('{32'hFFF10093, '{CU_ADDI, 20'h00FFF, 5'd1, 5'd2, 5'd0, 1'b0}});
    tbl.push_back('{32'h405201B3, '{CU_SUB, 20'h0, 5'd3, 5'd4, 5'd5, 1'b0}});
    tbl.push_back('{32'hFE000EE3, '{CU_BEQ, 20'h00FFE, 5'd0, 5'd0, 5'd0, 1'b0}});
    tbl.push_back('{32'h00000013, '{CU_ADDI, 20'h0, 5'd0, 5'd0, 5'd0, 1'b0}});
    tbl.push_back('{32'h008000EF, '{CU_JAL, 20'h00004, 5'd1, 5'd0, 5'd0, 1'b0}});
    tbl.push_back('{32'h00532623, '{CU_SW, 20'h0000C, 5'd0, 5'd6, 5'd5, 1'b0}});
    tbl.push_back('{32'h40345393, '{CU_SRAI, 20'h00403, 5'd7, 5'd8, 5'd0, 1'b0}});
    tbl.push_back('{32'h12345517, '{CU_AUIPC, 20'h12345, 5'd10, 5'd0, 5'd0, 1'b0}});
    tbl.push_back('{32'hFFFFFFFF, '{CU_NOP, 20'h0, 5'd0, 5'd0, 5'd0, ILL_EN}});
    tbl.push_back('{32'h0000000B, '{CU_NOP, 20'h0, 5'd0, 5'd0, 5'd0, ILL_EN}});
    tbl.push_back('{32'h023100B3, '{CU_NOP, 20'h0, 5'd0, 5'd0, 5'd0, ILL_EN}});
    nRst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check_ent("rst", '0);
    nRst = 1'b1;
    @(negedge clk);
    for (int n = 0; n < tbl.size(); n++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = tbl[n].instr;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("tbl%0d.valid", n), 32'(bus.out_valid), 32'd1);
      check_ent($sformatf("tbl%0d", n), tbl[n].e);
      @(negedge clk);
    end
    // back-to-back stream, no bubbles
    cycle(1'b1, 32'hABCDE2B7, 1'b0, 1'b1);
    cycle(1'b1, 32'hFFF10093, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    // backpressure: third word waits for space
    cycle(1'b1, 32'h00532623, 1'b0, 1'b0);
    cycle(1'b1, 32'h40345393, 1'b0, 1'b0);
    cycle(1'b1, 32'h008000EF, 1'b0, 1'b0);
    cycle(1'b1, 32'h008000EF, 1'b0, 1'b0);
    cycle(1'b1, 32'h008000EF, 1'b0, 1'b1);
    cycle(1'b1, 32'h008000EF, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    // flush when full and when partly full
    cycle(1'b1, 32'h00532623, 1'b0, 1'b0);
    cycle(1'b1, 32'h40345393, 1'b0, 1'b0);
    cycle(1'b1, 32'h008000EF, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00532623, 1'b0, 1'b0);
    cycle(1'b1, 32'h405201B3, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    // async reset while full
    cycle(1'b1, 32'h00532623, 1'b0, 1'b0);
    cycle(1'b1, 32'h40345393, 1'b0, 1'b0);
    check_outputs();
    nRst = 1'b0;
    #1;
    chk("arst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst.cuop", 32'(bus.out_cuop), 32'(CU_NOP));
    q.delete();
    @(negedge clk);
    nRst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        k = $urandom_range(0, pats.size() - 1);
        ins = ($urandom() & ~pats[k].mask) | pats[k].match;
      end else ins = $urandom();
      cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    end
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
